// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// uart_receiver : 8N1 UART receiver (8E1 with UART_RX_PARITY_EN) with a
//                 one-byte valid/ready holding register. Rev 1.0
// ============================================================================
module uart_receiver #(
   parameter int clock_freq = 32000000,
   parameter int baud_rate  = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       overrun,
   output logic       frame_error,
`ifdef UART_RX_PARITY_EN
   output logic       parity_error,
`endif
   output logic       busy
);

   localparam int BIT_CYCLES  = clock_freq / baud_rate;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int CNT_W       = (BIT_CYCLES > 511) ? $clog2(BIT_CYCLES) : 9;

   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_VOTE0   = CNT_W'(HALF_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_VOTE1   = CNT_W'(HALF_CYCLES);
   localparam logic [CNT_W-1:0] C_VOTE2   = CNT_W'(HALF_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_BIT_END = CNT_W'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_s_q, rx_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [1:0]       smp_q, smp_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             frame_error_q, frame_error_d;
   logic             busy_q;
`ifdef UART_RX_PARITY_EN
   logic             par_q, par_d;
   logic             parity_error_q, parity_error_d;
`endif

   logic             w_maj;
   logic             w_at_vote;
   logic             w_at_end;
   logic             w_commit;
   logic             w_ferr;
`ifdef UART_RX_PARITY_EN
   logic             w_perr;
`endif

   assign w_at_vote = (cnt_q == C_VOTE2);
   assign w_at_end  = (cnt_q == C_BIT_END);
   // Two earlier votes are stored; the third is the live synchronized line.
   assign w_maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + C_ONE;
      idx_d    = idx_q;
      smp_d    = smp_q;
      shift_d  = shift_q;
      w_commit = 1'b0;
      w_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d    = par_q;
      w_perr   = 1'b0;
`endif

      if (cnt_q == C_VOTE0) smp_d[0] = rx_s_q;
      if (cnt_q == C_VOTE1) smp_d[1] = rx_s_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s_q && rx_prev_q) state_d = S_START;
         end
         S_START: begin
            if (w_at_vote && w_maj) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (w_at_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               idx_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (w_at_vote) shift_d = {w_maj, shift_q[7:1]};
            if (w_at_end) begin
               cnt_d = '0;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (w_at_vote) par_d = w_maj;
            if (w_at_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            // Decide mid-stop-bit so a following start edge is never missed.
            if (w_at_vote) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               if (!w_maj) begin
                  w_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (^{shift_q, par_q}) begin
                  w_perr = 1'b1;
`endif
               end else begin
                  w_commit = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      data_d        = data_q;
      valid_d       = valid_q;
      overrun_d     = 1'b0;
      frame_error_d = w_ferr;
`ifdef UART_RX_PARITY_EN
      parity_error_d = w_perr;
`endif
      if (w_commit) begin
         if (!valid_q || ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_q     <= 1'b1;
         rx_s_q        <= 1'b1;
         rx_prev_q     <= 1'b1;
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         idx_q         <= 3'd0;
         smp_q         <= 2'b11;
         shift_q       <= 8'h00;
         data_q        <= 8'h00;
         valid_q       <= 1'b0;
         overrun_q     <= 1'b0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q          <= 1'b0;
         parity_error_q <= 1'b0;
`endif
      end else begin
         rx_meta_q     <= rx;
         rx_s_q        <= rx_meta_q;
         rx_prev_q     <= rx_s_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         smp_q         <= smp_d;
         shift_q       <= shift_d;
         data_q        <= data_d;
         valid_q       <= valid_d;
         overrun_q     <= overrun_d;
         frame_error_q <= frame_error_d;
         busy_q        <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
         par_q          <= par_d;
         parity_error_q <= parity_error_d;
`endif
      end
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign overrun     = overrun_q;
   assign frame_error = frame_error_q;
   assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error = parity_error_q;
`endif

endmodule
`default_nettype wire
